pmem_line_responder: RTL

- Physical-memory-side responder for the LC-3b cache's line-fill/writeback interface.
- Accepts one 128-bit line read or write request from the cache controller and completes it after a programmable latency with a single-cycle pmem_resp pulse.
- Holds a small line-addressed backing store, so cache miss, fill and writeback paths can be exercised without an external memory model.

---
 rtl/lc3b_types.sv | 29 ++
 rtl/pmem_line_array.sv | 52 +++++
 rtl/pmem_line_responder.sv | 121 ++++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// ============================================================================
//  Module      : lc3b_types (package)
//  Description : Shared LC-3b datapath and cache-interface types, including
//                the physical-memory responder state and line address types.
//  Revision    : 1.0 - initial pmem line responder support
// ============================================================================
`default_nettype none

package lc3b_types;

    // 16-bit machine word / byte address
    typedef logic [15:0]  lc3b_word;

    // One 128-bit cache line
    typedef logic [127:0] lc3b_c_line;

    // Line-granular address (byte address with the 4 offset bits dropped)
    typedef logic [11:0]  lc3b_line_addr;

    // Physical-memory responder states
    typedef enum logic [1:0] {
        pm_idle = 2'd0,
        pm_busy = 2'd1,
        pm_resp = 2'd2
    } lc3b_pmem_state;

endpackage : lc3b_types

`default_nettype wire

// File: rtl/pmem_line_array.sv
// ============================================================================
//  Module      : pmem_line_array
//  Description : NUM_LINES x 128-bit line store with one synchronous write
//                port, one registered read port and asynchronous clear.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pmem_line_array
    import lc3b_types::*;
#(
    parameter int NUM_LINES = 32,
    parameter int IDX_W     = $clog2(NUM_LINES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  lc3b_c_line       wdata,
    input  logic             re,
    input  logic [IDX_W-1:0] raddr,
    output lc3b_c_line       rdata
);

    lc3b_c_line r_lines [NUM_LINES];
    lc3b_c_line r_rdata;

    // Line storage: cleared on reset, one line written per enabled cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                r_lines[i] <= '0;
            end
        end else if (we) begin
            r_lines[waddr] <= wdata;
        end
    end

    // Read register: captures a line on request and holds it otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (re) begin
            r_rdata <= r_lines[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule : pmem_line_array

`default_nettype wire

// File: rtl/pmem_line_responder.sv
// ============================================================================
//  Module      : pmem_line_responder
//  Description : Physical-memory responder for the LC-3b cache line
//                fill/writeback port. Serves one line read or write at a
//                time after a fixed latency, backed by a local line store.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pmem_line_responder
    import lc3b_types::*;
#(
    parameter int LATENCY   = 4,
    parameter int NUM_LINES = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  lc3b_word   pmem_address,
    input  logic       pmem_read,
    input  logic       pmem_write,
    input  lc3b_c_line pmem_wdata,
    output lc3b_c_line pmem_rdata,
    output logic       pmem_resp,
    output logic       busy
);

    localparam int         c_idx_w    = $clog2(NUM_LINES);
    localparam logic [3:0] c_lat_init = 4'(LATENCY - 1);

    lc3b_pmem_state       r_state;
    logic [3:0]           r_cnt;
    logic                 r_is_write;
    logic [c_idx_w-1:0]   r_index;
    lc3b_c_line           r_wdata;
    logic                 r_resp;
    logic                 r_busy;

    lc3b_line_addr        w_line_addr;
    logic [c_idx_w-1:0]   w_index;
    logic                 w_req;
    logic                 w_commit;
    logic                 w_unused_addr_bits;

    // Upper line-address bits beyond the store depth alias onto lower lines
    assign w_line_addr        = pmem_address[15:4];
    assign w_index            = w_line_addr[c_idx_w-1:0];
    assign w_unused_addr_bits = ^{pmem_address[3:0], w_line_addr};
    assign w_req              = pmem_read | pmem_write;

    // The store is touched only on the final BUSY cycle of a live request
    assign w_commit = (r_state == pm_busy) && w_req && (r_cnt == 4'd0);

    // Request FSM with latency countdown; op, index and data frozen at accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= pm_idle;
            r_cnt      <= 4'd0;
            r_is_write <= 1'b0;
            r_index    <= '0;
            r_wdata    <= '0;
            r_resp     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            unique case (r_state)
                pm_idle: begin
                    r_resp <= 1'b0;
                    if (w_req) begin
                        // write wins when both strobes are raised together
                        r_is_write <= pmem_write;
                        r_index    <= w_index;
                        r_wdata    <= pmem_wdata;
                        r_cnt      <= c_lat_init;
                        r_busy     <= 1'b1;
                        r_state    <= pm_busy;
                    end
                end
                pm_busy: begin
                    if (!w_req) begin
                        r_busy  <= 1'b0;
                        r_state <= pm_idle;
                    end else if (r_cnt == 4'd0) begin
                        r_resp  <= 1'b1;
                        r_state <= pm_resp;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                pm_resp: begin
                    r_resp  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= pm_idle;
                end
                default: begin
                    r_resp  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= pm_idle;
                end
            endcase
        end
    end

    pmem_line_array #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (c_idx_w)
    ) u_line_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (w_commit & r_is_write),
        .waddr (r_index),
        .wdata (r_wdata),
        .re    (w_commit & ~r_is_write),
        .raddr (r_index),
        .rdata (pmem_rdata)
    );

    assign pmem_resp = r_resp;
    assign busy      = r_busy;

endmodule : pmem_line_responder

`default_nettype wire
